// File: rtl/stream_dmux_n.sv
// stream_dmux_n: 1-to-N registered valid/ready stream demultiplexer.
// Steers in_data to channel in_sel through a one-entry register per channel.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_data/in_sel        input word and destination channel index
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   out_data              packed channel words, ch k = [k*WIDTH +: WIDTH]
//   out_valid/out_ready   per-channel output handshakes
//   bad_sel               sticky flag: a word with in_sel >= CHANNELS was taken
//   out_count             per-channel delivered-beat counters
//
// Optional feature macro: DMUX_COUNT_EN adds out_count and the counters.
module stream_dmux_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      bad_sel
`ifdef DMUX_COUNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0] out_count
`endif
);

    localparam int NSEL = 1 << SEL_W;

    logic [WIDTH-1:0]    data_q [CHANNELS];
    logic [CHANNELS-1:0] valid_q;
    logic                bad_q;

    // Per-code ready / out-of-range tables, indexed by in_sel.
    // Codes past CHANNELS are always ready so bad words drain.
    logic [NSEL-1:0]     rdy_v;
    logic [NSEL-1:0]     bad_v;
    logic [CHANNELS-1:0] acc_v;
    logic [CHANNELS-1:0] dlv_v;
    logic                take;

    for (genvar i = 0; i < NSEL; i++) begin : g_sel
        if (i < CHANNELS) begin : g_ok
            assign rdy_v[i] = !valid_q[i] || out_ready[i];
            assign bad_v[i] = 1'b0;
        end else begin : g_bad
            assign rdy_v[i] = 1'b1;
            assign bad_v[i] = 1'b1;
        end
    end

    assign in_ready = rdy_v[in_sel];
    assign take     = in_valid && in_ready;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign acc_v[k] = take && (in_sel == SEL_W'(k));
        assign dlv_v[k] = valid_q[k] && out_ready[k];
        assign out_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign out_valid = valid_q;
    assign bad_sel   = bad_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            bad_q   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (take && bad_v[in_sel]) begin
                bad_q <= 1'b1;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                // A new word wins over delivery: no bubble on refill.
                if (acc_v[k]) begin
                    data_q[k]  <= in_data;
                    valid_q[k] <= 1'b1;
                end else if (dlv_v[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DMUX_COUNT_EN
    logic [CNT_W-1:0] cnt_q [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (dlv_v[k]) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_cnt
        assign out_count[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_stream_dmux_n.sv
// tb_stream_dmux_n: directed bench for stream_dmux_n.
// Instances: 4-channel (CNT_W=4) and 3-channel (out-of-range select).
module tb_stream_dmux_n;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] d4;
    logic [1:0]  s4;
    logic        v4;
    logic        r4;
    logic [63:0] od4;
    logic [3:0]  ov4;
    logic [3:0]  or4;
    logic        bs4;

    logic [15:0] d3;
    logic [1:0]  s3;
    logic        v3;
    logic        r3;
    logic [47:0] od3;
    logic [2:0]  ov3;
    logic [2:0]  or3;
    logic        bs3;

`ifdef DMUX_COUNT_EN
    logic [15:0] oc4;
    logic [47:0] oc3;
`endif

    int total = 0;
    int bad = 0;

    stream_dmux_n #(.WIDTH(16), .CHANNELS(4), .CNT_W(4)) u4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (d4),
        .in_sel    (s4),
        .in_valid  (v4),
        .in_ready  (r4),
        .out_data  (od4),
        .out_valid (ov4),
        .out_ready (or4),
        .bad_sel   (bs4)
`ifdef DMUX_COUNT_EN
        ,
        .out_count (oc4)
`endif
    );

    stream_dmux_n #(.WIDTH(16), .CHANNELS(3), .CNT_W(16)) u3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (d3),
        .in_sel    (s3),
        .in_valid  (v3),
        .in_ready  (r3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (or3),
        .bad_sel   (bs3)
`ifdef DMUX_COUNT_EN
        ,
        .out_count (oc3)
`endif
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        d4 = '0; s4 = '0; v4 = 1'b0; or4 = '0;
        d3 = '0; s3 = '0; v3 = 1'b0; or3 = '0;

        // reset state
        @(negedge clk);
        check("rst_valid", ov4, 0);
        check("rst_data", od4, 0);
        check("rst_bad4", bs4, 0);
        check("rst_bad3", bs3, 0);
        reset = 1'b0;

        // routing, out_ready all low
        d4 = 16'h1111; s4 = 2'd0; v4 = 1'b1;
        #1 check("rt_rdy0", r4, 1);
        @(negedge clk);
        check("rt_v0", ov4, 4'b0001);
        check("rt_d0", od4[15:0], 16'h1111);
        d4 = 16'h2222; s4 = 2'd1;
        #1 check("rt_rdy1", r4, 1);
        @(negedge clk);
        check("rt_v1", ov4, 4'b0011);
        d4 = 16'h3333; s4 = 2'd2;
        @(negedge clk);
        check("rt_v2", ov4, 4'b0111);
        d4 = 16'h4444; s4 = 2'd3;
        @(negedge clk);
        check("rt_v3", ov4, 4'b1111);
        v4 = 1'b0;
        check("rt_data", od4, 64'h4444_3333_2222_1111);

        // backpressure on ch2
        d4 = 16'h5555; s4 = 2'd2; v4 = 1'b1;
        #1 check("bp_rdy_lo", r4, 0);
        @(negedge clk);
        check("bp_hold_d", od4[47:32], 16'h3333);
        check("bp_hold_v", ov4, 4'b1111);
        or4 = 4'b0100;
        #1 check("bp_rdy_hi", r4, 1);
        @(negedge clk);
        check("bp_new_d", od4[47:32], 16'h5555);
        check("bp_no_bub", ov4, 4'b1111);
        v4 = 1'b0;
        @(negedge clk);
        check("bp_drain", ov4, 4'b1011);
        or4 = 4'b0000;

        // streaming to ch1
        or4 = 4'b0010;
        s4 = 2'd1;
        v4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d4 = 16'h1000 + 16'(i);
            #1 check("st_rdy", r4, 1);
            check("st_dlv", od4[31:16],
                  (i == 0) ? 16'h2222 : 16'h1000 + 16'(i - 1));
            check("st_vld", ov4[1], 1);
            @(negedge clk);
        end
        v4 = 1'b0;
        #1 check("st_last", od4[31:16], 16'h1007);
        check("st_v_last", ov4, 4'b1011);
        @(negedge clk);
        check("st_empty", ov4, 4'b1001);
        check("st_others", od4, 64'h4444_5555_1007_1111);
        or4 = 4'b0000;

        // out-of-range select on the 3-channel instance
        d3 = 16'hBEEF; s3 = 2'd3; v3 = 1'b1;
        #1 check("bs_rdy", r3, 1);
        @(negedge clk);
        v3 = 1'b0;
        check("bs_flag", bs3, 1);
        check("bs_novld", ov3, 0);
        check("bs_nodata", od3, 0);
        d3 = 16'h7777; s3 = 2'd0; v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        check("bs_sticky", bs3, 1);
        check("bs_ch0", ov3, 3'b001);
        check("bs_ch0_d", od3[15:0], 16'h7777);
        check("bs_u4_clr", bs4, 0);

        // mid-stream reset with out_valid = 0101
        d4 = 16'h6666; s4 = 2'd2; v4 = 1'b1;
        or4 = 4'b1000;
        @(negedge clk);
        v4 = 1'b0;
        or4 = 4'b0000;
        #1 check("mr_pre", ov4, 4'b0101);
        #2 reset = 1'b1;
        #1 check("mr_valid", ov4, 0);
        check("mr_data", od4, 0);
        check("mr_bad4", bs4, 0);
        check("mr_bad3", bs3, 0);
        check("mr_v3", ov3, 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef DMUX_COUNT_EN
        // 17 deliveries on ch0 with a 4-bit counter
        check("cnt_rst", oc4, 0);
        or4 = 4'b0001;
        s4 = 2'd0;
        v4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d4 = 16'(i);
            @(negedge clk);
        end
        v4 = 1'b0;
        @(negedge clk);
        check("cnt_wrap", oc4, 16'h0001);
        check("cnt_u3", oc3, 0);
        or4 = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
